// File: rtl/mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer
//
// Multi-cycle bus sequencer for a small CPU. One Avalon-style memory port is
// shared by instruction fetch and data load/store. This block orders the
// fetch, execute and data-access phases. It also issues the PC-advance,
// IR-load and load-writeback strobes to the datapath. A halt request or a
// bus watchdog timeout halts the CPU.
//
// State table:
//   state        | meaning
//   -------------+----------------------------------------------------------
//   FETCH_REQ    | drive PC onto the bus and request an instruction word
//   FETCH_DATA   | instruction word is on readdata; load it into IR
//   EXEC         | decode cycle; commit non-memory ops, else go to data phase
//   DATA_REQ     | drive the data address; read for a load, write for a store
//   DATA_CAPTURE | load data is on readdata; write back and commit
//   HALTED       | terminal until reset (halt request or watchdog timeout)
//
// Parameters:
//   MAX_WAIT        consecutive waitrequest cycles tolerated in one request
//                   state before bus_error is raised (1..255)
//
// Ports:
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   memory_hazard   current IR is a load or store
//   mem_write       current IR is a store; only meaningful with memory_hazard
//   halt_req        datapath PC equals the halt address
//   waitrequest     bus stall; a request is accepted when it is low
//   read, write     bus strobes (never both high)
//   addr_sel        0 = PC drives the address, 1 = computed data address
//   ir_load         capture readdata into IR
//   load_data_valid readdata is a load result; register writeback enable
//   pc_advance      commit the current instruction and update PC
//   active          CPU running
//   bus_error       sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_access_sequencer #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic memory_hazard,
  input  logic mem_write,
  input  logic halt_req,
  input  logic waitrequest,
  output logic read,
  output logic write,
  output logic addr_sel,
  output logic ir_load,
  output logic load_data_valid,
  output logic pc_advance,
  output logic active,
  output logic bus_error
);

  typedef enum logic [2:0] {
    FETCH_REQ    = 3'd0,
    FETCH_DATA   = 3'd1,
    EXEC         = 3'd2,
    DATA_REQ     = 3'd3,
    DATA_CAPTURE = 3'd4,
    HALTED       = 3'd5
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
  localparam logic [7:0] WAIT_SAT  = 8'hFF;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       bus_error_q;

  // Ungated decode of the outputs. These come from the current state and the
  // live inputs.
  logic rd_c;
  logic wr_c;
  logic as_c;
  logic il_c;
  logic ldv_c;
  logic pa_c;
  logic act_c;

  logic stall;
  logic timeout;

  always_comb begin
    rd_c  = 1'b0;
    wr_c  = 1'b0;
    as_c  = 1'b0;
    il_c  = 1'b0;
    ldv_c = 1'b0;
    pa_c  = 1'b0;
    act_c = 1'b0;
    case (state)
      FETCH_REQ: begin
        act_c = 1'b1;
        // A pending halt suppresses the fetch so no new instruction starts.
        rd_c  = ~halt_req;
      end
      FETCH_DATA: begin
        act_c = 1'b1;
        il_c  = 1'b1;
      end
      EXEC: begin
        act_c = 1'b1;
        pa_c  = ~memory_hazard;
      end
      DATA_REQ: begin
        act_c = 1'b1;
        as_c  = 1'b1;
        rd_c  = ~mem_write;
        wr_c  = mem_write;
        // A store commits on the cycle its write is accepted.
        pa_c  = mem_write & ~waitrequest;
      end
      DATA_CAPTURE: begin
        act_c = 1'b1;
        as_c  = 1'b1;
        ldv_c = 1'b1;
        pa_c  = 1'b1;
      end
      default: begin
        // HALTED: everything stays low.
      end
    endcase
  end

  // The state resets asynchronously to FETCH_REQ. FETCH_REQ would drive
  // read, so every output is also gated with reset_n. This keeps all of them
  // low for as long as reset is held.
  assign read            = rd_c  & reset_n;
  assign write           = wr_c  & reset_n;
  assign addr_sel        = as_c  & reset_n;
  assign ir_load         = il_c  & reset_n;
  assign load_data_valid = ldv_c & reset_n;
  assign pc_advance      = pa_c  & reset_n;
  assign active          = act_c & reset_n;
  assign bus_error       = bus_error_q;

  // stall: a strobe is up but the bus is not taking it this cycle.
  // timeout: this is the last stall cycle the watchdog allows.
  assign stall   = (rd_c | wr_c) & waitrequest;
  assign timeout = stall & (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH_REQ;
      wait_cnt    <= 8'd0;
      bus_error_q <= 1'b0;
    end else begin
      case (state)
        FETCH_REQ: begin
          if (halt_req) begin
            state    <= HALTED;
            wait_cnt <= 8'd0;
          end else if (timeout) begin
            state       <= HALTED;
            bus_error_q <= 1'b1;
            wait_cnt    <= 8'd0;
          end else if (!waitrequest) begin
            state    <= FETCH_DATA;
            wait_cnt <= 8'd0;
          end else if (wait_cnt != WAIT_SAT) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        FETCH_DATA: begin
          state    <= EXEC;
          wait_cnt <= 8'd0;
        end
        EXEC: begin
          state    <= memory_hazard ? DATA_REQ : FETCH_REQ;
          wait_cnt <= 8'd0;
        end
        DATA_REQ: begin
          if (timeout) begin
            state       <= HALTED;
            bus_error_q <= 1'b1;
            wait_cnt    <= 8'd0;
          end else if (!waitrequest) begin
            state    <= mem_write ? FETCH_REQ : DATA_CAPTURE;
            wait_cnt <= 8'd0;
          end else if (wait_cnt != WAIT_SAT) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DATA_CAPTURE: begin
          state    <= FETCH_REQ;
          wait_cnt <= 8'd0;
        end
        HALTED: begin
          state    <= HALTED;
          wait_cnt <= 8'd0;
        end
        default: begin
          state    <= FETCH_REQ;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_access_sequencer
//
// Directed bench for mem_access_sequencer with MAX_WAIT = 16.
// Inputs change 1 ns after each rising edge. Outputs are sampled 3 ns later.
// The packed view compared at every step is:
//   {read, write, addr_sel, ir_load, load_data_valid, pc_advance, active,
//    bus_error}
// -----------------------------------------------------------------------------
module tb_mem_access_sequencer;

  logic clk;
  logic reset_n;
  logic memory_hazard;
  logic mem_write;
  logic halt_req;
  logic waitrequest;
  logic read;
  logic write;
  logic addr_sel;
  logic ir_load;
  logic load_data_valid;
  logic pc_advance;
  logic active;
  logic bus_error;

  logic [7:0] outs;
  int vectors;
  int miscompares;

  // Expected output patterns
  localparam logic [7:0] O_IDLE   = 8'b0000_0000;
  localparam logic [7:0] O_FREQ   = 8'b1000_0010;
  localparam logic [7:0] O_FDATA  = 8'b0001_0010;
  localparam logic [7:0] O_EXEC_C = 8'b0000_0110;
  localparam logic [7:0] O_EXEC_M = 8'b0000_0010;
  localparam logic [7:0] O_LDREQ  = 8'b1010_0010;
  localparam logic [7:0] O_LDCAP  = 8'b0010_1110;
  localparam logic [7:0] O_STWAIT = 8'b0110_0010;
  localparam logic [7:0] O_STACC  = 8'b0110_0110;
  localparam logic [7:0] O_BUSERR = 8'b0000_0001;

  mem_access_sequencer #(.MAX_WAIT(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .memory_hazard   (memory_hazard),
    .mem_write       (mem_write),
    .halt_req        (halt_req),
    .waitrequest     (waitrequest),
    .read            (read),
    .write           (write),
    .addr_sel        (addr_sel),
    .ir_load         (ir_load),
    .load_data_valid (load_data_valid),
    .pc_advance      (pc_advance),
    .active          (active),
    .bus_error       (bus_error)
  );

  assign outs = {read, write, addr_sel, ir_load, load_data_valid, pc_advance,
                 active, bus_error};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, move to next cycle.
  task automatic cyc(input string tag, input logic mh, input logic mw,
                     input logic hr, input logic wr, input logic [7:0] exp);
    memory_hazard = mh;
    mem_write     = mw;
    halt_req      = hr;
    waitrequest   = wr;
    #3;
    chk(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset_n       = 1'b0;
    memory_hazard = 1'b0;
    mem_write     = 1'b0;
    halt_req      = 1'b0;
    waitrequest   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs, O_IDLE);
    reset_n = 1'b1;

    // Three non-memory instructions, three cycles each
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("nm%0d_fetch", i), 0, 0, 0, 0, O_FREQ);
      cyc($sformatf("nm%0d_irload", i), 0, 0, 0, 0, O_FDATA);
      cyc($sformatf("nm%0d_exec", i), 0, 0, 0, 0, O_EXEC_C);
    end

    // Load with no wait states. Inputs that are out of phase are ignored.
    cyc("ld_fetch", 1, 0, 0, 0, O_FREQ);
    cyc("ld_irload_wr_ignored", 0, 0, 0, 1, O_FDATA);
    cyc("ld_exec", 1, 0, 0, 0, O_EXEC_M);
    cyc("ld_dreq", 1, 0, 0, 0, O_LDREQ);
    cyc("ld_capture", 0, 0, 0, 1, O_LDCAP);

    // Store with 3 waitrequest cycles in DATA_REQ (7-cycle instruction)
    cyc("st_fetch", 0, 0, 0, 0, O_FREQ);
    cyc("st_irload", 0, 0, 0, 0, O_FDATA);
    cyc("st_exec", 1, 1, 0, 0, O_EXEC_M);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("st_wait%0d", i), 1, 1, 0, 1, O_STWAIT);
    cyc("st_accept", 1, 1, 0, 0, O_STACC);

    // Fetch stalled 2 cycles. halt_req is ignored outside FETCH_REQ.
    cyc("fw_stall0", 0, 0, 0, 1, O_FREQ);
    cyc("fw_stall1", 0, 0, 0, 1, O_FREQ);
    cyc("fw_accept", 0, 0, 0, 0, O_FREQ);
    cyc("fw_irload_halt_ignored", 0, 0, 1, 0, O_FDATA);
    cyc("fw_exec", 0, 0, 0, 0, O_EXEC_C);

    // halt_req raised during EXEC of a load: the load still completes
    cyc("hl_fetch", 0, 0, 0, 0, O_FREQ);
    cyc("hl_irload", 0, 0, 0, 0, O_FDATA);
    cyc("hl_exec", 1, 0, 1, 0, O_EXEC_M);
    cyc("hl_dreq", 1, 0, 1, 0, O_LDREQ);
    cyc("hl_capture", 1, 0, 1, 0, O_LDCAP);
    halt_req = 1'b1;
    #3;
    chk("hl_no_fetch_read", {7'd0, read}, 8'd0);
    @(posedge clk);
    #1;
    cyc("hl_halted0", 0, 0, 0, 0, O_IDLE);
    cyc("hl_halted1", 1, 0, 1, 1, O_IDLE);
    cyc("hl_halted2", 0, 0, 0, 0, O_IDLE);

    // Reset out of HALTED
    reset_n = 1'b0;
    #1;
    chk("halt_reset_outputs", outs, O_IDLE);
    reset_n = 1'b1;

    // Reset mid-store drops write at once. Restart fetches with no commit.
    cyc("ab_fetch", 0, 0, 0, 0, O_FREQ);
    cyc("ab_irload", 0, 0, 0, 0, O_FDATA);
    cyc("ab_exec", 1, 1, 0, 0, O_EXEC_M);
    memory_hazard = 1'b1;
    mem_write     = 1'b1;
    waitrequest   = 1'b1;
    #3;
    chk("ab_dreq_write", outs, O_STWAIT);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ab_reset_async", outs, O_IDLE);
    #1;
    reset_n       = 1'b1;
    memory_hazard = 1'b0;
    mem_write     = 1'b0;
    waitrequest   = 1'b0;
    #1;
    chk("ab_restart_fetch", outs, O_FREQ);
    @(posedge clk);
    #1;
    cyc("ab_irload2", 0, 0, 0, 0, O_FDATA);
    cyc("ab_exec2", 0, 0, 0, 0, O_EXEC_C);

    // 15 stalls (wait_cnt reaches MAX_WAIT-1) then accept: no error
    for (int i = 0; i < 15; i++)
      cyc($sformatf("wd15_stall%0d", i), 0, 0, 0, 1, O_FREQ);
    cyc("wd15_accept", 0, 0, 0, 0, O_FREQ);
    cyc("wd15_irload", 0, 0, 0, 0, O_FDATA);
    cyc("wd15_exec", 0, 0, 0, 0, O_EXEC_C);

    // Permanent stall: read for 16 cycles, then bus_error and halt
    for (int i = 0; i < 16; i++)
      cyc($sformatf("wd_stall%0d", i), 0, 0, 0, 1, O_FREQ);
    cyc("wd_error0", 0, 0, 0, 1, O_BUSERR);
    cyc("wd_error1", 0, 0, 0, 0, O_BUSERR);
    cyc("wd_error2", 1, 1, 0, 0, O_BUSERR);

    // Reset clears the sticky error
    reset_n = 1'b0;
    #1;
    chk("err_reset_outputs", outs, O_IDLE);
    reset_n = 1'b1;
    #1;
    chk("err_restart_fetch", outs, O_FREQ);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Multi-cycle bus sequencer that consumes memory_hazard from the hazard detector.
- Owns the single Avalon-style memory port shared by instruction fetch and data load/store.
- Orders fetch, execute and data-access phases, and issues PC-advance, IR-load and load-writeback strobes to the datapath.
- Halts the CPU on a halt request or on a bus watchdog timeout.

Parameters:
MAX_WAIT, 16, consecutive waitrequest cycles tolerated in one request state before bus_error; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- memory_hazard  in  1  from hazard detector; current IR is a load or store
- mem_write  in  1  current IR is a store (SB/SH/SW); qualified by memory_hazard
- halt_req  in  1  datapath PC equals halt address
- waitrequest  in  1  bus stall; a request is accepted on a cycle with read|write=1 and waitrequest=0
- read  out  1  bus read strobe
- write  out  1  bus write strobe
- addr_sel  out  1  0 = PC drives address, 1 = computed data address
- ir_load  out  1  capture readdata into IR this cycle
- load_data_valid  out  1  readdata is load result; register writeback enable
- pc_advance  out  1  commit current instruction, update PC
- active  out  1  CPU running
- bus_error  out  1  sticky watchdog flag

Behaviour:
- Reset (async, any state): state=FETCH_REQ, wait_cnt=0, bus_error=0.
- While reset_n=0: read=write=ir_load=load_data_valid=pc_advance=0, addr_sel=0, active=0.
- Outputs are combinational from state and inputs; all strobes are single-cycle.
- read and write are never high together.
- FETCH_REQ:
  - halt_req=1: read=0, go HALTED; halt_req has priority over fetch.
  - Otherwise read=1, addr_sel=0.
  - Accepted (waitrequest=0): go FETCH_DATA. Else stay.
- FETCH_DATA: ir_load=1; go EXEC.
- EXEC: sample memory_hazard and mem_write.
  - memory_hazard=0: pc_advance=1, go FETCH_REQ.
  - memory_hazard=1: go DATA_REQ.
- DATA_REQ: addr_sel=1; read=~mem_write, write=mem_write.
  - Accepted, store: pc_advance=1, go FETCH_REQ.
  - Accepted, load: go DATA_CAPTURE.
  - Else stay.
- DATA_CAPTURE: addr_sel=1, load_data_valid=1, pc_advance=1; go FETCH_REQ.
- HALTED: terminal until reset; active=0, all strobes 0.
- active=1 in every state except HALTED.
- Latency with waitrequest=0 throughout:
  - non-memory instruction: 3 cycles
  - store: 4 cycles
  - load: 5 cycles
  - each waitrequest cycle adds 1.
- Watchdog:
  - wait_cnt is an 8-bit counter.
  - Increments on each cycle in FETCH_REQ/DATA_REQ with the strobe high and waitrequest=1.
  - Clears on acceptance and on any state change.
  - If waitrequest=1 while wait_cnt==MAX_WAIT-1: set bus_error=1, drop strobes the next cycle, go HALTED. No pc_advance.
  - Saturates; never wraps.
- Boundaries:
  - halt_req in any state other than FETCH_REQ is ignored; the in-flight instruction completes.
  - waitrequest outside request states is ignored.
  - memory_hazard/mem_write are only sampled in EXEC and DATA_REQ.
  - Reset mid-transaction aborts it: no pc_advance, no load_data_valid. Restart is FETCH_REQ.

Test Plan:
1. Release reset, waitrequest=0, memory_hazard=0 for 3 instructions -> read=1/addr_sel=0 in cycles 1,4,7; ir_load in cycles 2,5,8; pc_advance in cycles 3,6,9; write never high.
2. Load (memory_hazard=1, mem_write=0), waitrequest=0 -> cycle 4 read=1/addr_sel=1; cycle 5 load_data_valid=1 and pc_advance=1; next fetch in cycle 6.
3. Store (memory_hazard=1, mem_write=1), waitrequest high 3 cycles in DATA_REQ -> write=1 held 4 cycles, read=0; pc_advance on the 4th (accept) cycle; 7-cycle instruction.
4. waitrequest held permanently in FETCH_REQ with MAX_WAIT=16 -> read high 16 cycles, then read=0, bus_error=1, active=0; stays there with no further strobes.
5. halt_req=1 during EXEC of a load -> load completes (load_data_valid, pc_advance); next cycle read=0, active=0.
6. reset_n low in DATA_REQ with write=1 -> write drops immediately with no clock edge; after release, read=1/addr_sel=0 with no pc_advance for the aborted store.
